wb_regfile: RTL

- Consumer end of the MEM/WB pipeline boundary in the 16-bit, 5-stage core.
- Takes the latched write-back control and data from MEM/WB and selects the write-back value (memory data or ALU result).
- Commits that value into an 8 x 16-bit architectural register file.
- Serves the two decode-stage read ports, with write-to-read bypass so decode sees a same-cycle write-back without an extra stall.

---
 rtl/wb_regfile.sv | 78 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it into an
// NREG x WIDTH array, and serves two combinational read ports with write-to-read bypass.
module wb_regfile #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREG  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_en,
   input  logic                      mem_to_reg,
   input  logic                      reg_w_en,
   input  logic [$clog2(NREG)-1:0]   w_reg,
   input  logic [WIDTH-1:0]          ALU_out,
   input  logic [WIDTH-1:0]          mem_out,
   input  logic [$clog2(NREG)-1:0]   r_reg1,
   input  logic [$clog2(NREG)-1:0]   r_reg2,
   output logic [WIDTH-1:0]          r_data1,
   output logic [WIDTH-1:0]          r_data2,
   output logic [WIDTH-1:0]          wb_data,
   output logic                      wb_valid,
   output logic [15:0]               commit_cnt
);

   localparam int unsigned IDXW = $clog2(NREG);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [15:0]      cnt_q;
   logic [15:0]      cnt_d;

   always_comb begin
      wb_data  = mem_to_reg ? mem_out : ALU_out;
      wb_valid = reg_w_en & wb_en;
   end

   // One enable per register keeps the write decode explicit and the reset per-flop.
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      logic we;
      assign we = wb_valid && (w_reg == IDXW'(i));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            regs_q[i] <= '0;
         end else if (we) begin
            regs_q[i] <= wb_data;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wb_valid) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign commit_cnt = cnt_q;

   // Bypass lets decode see a value committing on this very edge.
   always_comb begin
      r_data1 = regs_q[r_reg1];
      r_data2 = regs_q[r_reg2];
      if (wb_valid && (w_reg == r_reg1)) begin
         r_data1 = wb_data;
      end
      if (wb_valid && (w_reg == r_reg2)) begin
         r_data2 = wb_data;
      end
   end

endmodule
